bert_run_controller: RTL and testbench
======================================

Name: bert_run_controller

Overview:
Sequences one bit-error-rate test run around the link error injector and the receive-side checker.
- Gates the injector through its stop input: warm-up, then an injection window, then a drain window.
- Counts received bits and detected errors.
- Snapshots the injector's running error total, then flags any mismatch between injected and detected errors.
Sits in the test-harness layer, between the host/testbench control and the injector/checker pair.

Parameters:
CNT_W, 32, width of cycle-count config inputs and of bit/error counters
INJ_W, 64, width of injector running error total
DRAIN_CYCLES, 16, fixed drain length in cycles; must be >= link delay-line depth

Ports:
clock  in  1  sole clock, rising edge
reset  in  1  synchronous, active-low reset
start  in  1  begin a run; honoured only in IDLE or DONE
abort  in  1  cancel a run in progress
cfg_warmup  in  CNT_W  warm-up cycles, injection stopped
cfg_run  in  CNT_W  injection-window cycles
rx_valid  in  1  checker compared one bit this cycle
rx_error  in  1  compared bit was wrong (qualified by rx_valid)
inj_errors  in  INJ_W  injector running error total
inject_stop  out  1  drives injector stop
busy  out  1  state in WARMUP/RUN/DRAIN
done  out  1  run complete, results valid
aborted  out  1  one-cycle pulse on abort
bit_count  out  CNT_W  valid bits seen in RUN+DRAIN
error_count  out  CNT_W  errored bits seen in RUN+DRAIN
inj_delta  out  INJ_W  errors injected during the run
mismatch  out  1  inj_delta != zero-extended error_count

Behaviour:
- Reset (reset==0 at a rising edge):
  - state=IDLE, inject_stop=1, busy=0, done=0, aborted=0, mismatch=0.
  - All counters and inj_delta = 0.
- States are IDLE, WARMUP, RUN, DRAIN, DONE. Registered outputs; state changes take effect at the next rising edge.
- IDLE/DONE + start=1 (abort=0):
  - Next cycle: state=WARMUP, done=0, bit_count=error_count=inj_delta=0, mismatch=0.
  - cfg_warmup and cfg_run latched into internal down-counters.
  - cfg inputs are ignored thereafter.
- start while busy is ignored.
- WARMUP:
  - inject_stop=1, no counting.
  - Lasts exactly cfg_warmup cycles; cfg_warmup=0 gives a 1-cycle WARMUP.
  - On exit, inj_errors is snapshotted into an internal register.
- RUN:
  - inject_stop=0.
  - Lasts exactly max(cfg_run,1) cycles, then DRAIN.
- DRAIN:
  - inject_stop=1.
  - Lasts exactly DRAIN_CYCLES cycles so in-flight errors reach the checker.
  - On exit: inj_delta = inj_errors - snapshot (mod 2^INJ_W), and mismatch is computed from the final counts.
  - Next state DONE.
- Counting, in RUN and DRAIN only:
  - bit_count += rx_valid.
  - error_count += rx_valid & rx_error.
  - Both counters saturate at 2^CNT_W-1; they never wrap.
  - rx_error without rx_valid is ignored.
- DONE:
  - done=1, inject_stop=1.
  - Results are held stable until the next start or reset.
- abort=1 in WARMUP/RUN/DRAIN:
  - Next cycle: state=IDLE, inject_stop=1, busy=0, done=0.
  - aborted=1 for exactly one cycle.
  - Counters keep their partial values and inj_delta is not updated.
- abort in IDLE/DONE is a no-op; start+abort in the same cycle: abort wins, start is dropped.
- reset==0 mid-run: immediate return to the reset state at that edge; no aborted pulse.
- inject_stop must be 1 in every state except RUN, so no errors are injected outside the window.

Decomposition:
- Shared package bert_pkg:
  - state enum (IDLE, WARMUP, RUN, DRAIN, DONE);
  - default CNT_W/INJ_W constants;
  - saturation max-value function.
- One natural sub-module, bert_sat_counter (CNT_W-wide, clear/increment/saturate), instantiated twice for bit_count and error_count.
- The phase down-counter lives inline in the FSM.

Test Plan:
- Basic run:
  - Stimulus: cfg_warmup=4, cfg_run=100, rx_valid=1 every cycle, no errors, inj_errors constant 0.
  - Response: inject_stop low for exactly 100 cycles; done rises 4+100+16+1 cycles after start; bit_count=116, error_count=0, mismatch=0.
- Matched injection:
  - Stimulus: inj_errors steps 10→13 during RUN; three rx_error pulses, one arriving in DRAIN.
  - Response: inj_delta=3, error_count=3, mismatch=0.
- Lost error:
  - Stimulus: inj_errors +2, only one rx_error seen.
  - Response: inj_delta=2, error_count=1, mismatch=1.
- Abort:
  - Stimulus: abort at RUN cycle 50.
  - Response: next cycle state IDLE, inject_stop=1, aborted pulse width 1, done=0; a later start runs normally.
- Boundaries:
  - Stimulus: cfg_warmup=0, cfg_run=0, CNT_W=4 build with 20 valid error bits.
  - Response: WARMUP=1 cycle, RUN=1 cycle, bit_count=error_count=15 (saturated).
- Start in flight / reset mid-run:
  - Stimulus: start while busy; separately, reset low during DRAIN.
  - Response: start ignored, with no counter clear. On reset: all outputs at reset values one edge later.

Source files
------------

// File: rtl/bert_pkg.sv
// bert_pkg: shared state codes, default widths and saturation helper for the BERT run controller.
package bert_pkg;
  localparam int CNT_W_DEF = 32;
  localparam int INJ_W_DEF = 64;
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WARMUP = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  function automatic logic [63:0] sat_max(input int w);
    return (w >= 64) ? '1 : (64'd1 << w) - 64'd1;
  endfunction
endpackage

// File: rtl/bert_sat_counter.sv
// bert_sat_counter: clearable up-counter that sticks at its all-ones value instead of wrapping.
module bert_sat_counter
  import bert_pkg::*;
#(
  parameter int W = CNT_W_DEF
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);
  localparam logic [W-1:0] MAX = W'(sat_max(W));
  always_ff @(posedge clock)
    if (!reset || clear) count <= '0;
    else if (inc && count != MAX) count <= count + 1'b1;
endmodule

// File: rtl/bert_run_controller.sv
// bert_run_controller: sequences warm-up, injection and drain phases of one BERT run and
// reconciles injected against detected errors.
module bert_run_controller
  import bert_pkg::*;
#(
  parameter int CNT_W        = CNT_W_DEF,
  parameter int INJ_W        = INJ_W_DEF,
  parameter int DRAIN_CYCLES = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] cfg_warmup,
  input  logic [CNT_W-1:0] cfg_run,
  input  logic             rx_valid,
  input  logic             rx_error,
  input  logic [INJ_W-1:0] inj_errors,
  output logic             inject_stop,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] bit_count,
  output logic [CNT_W-1:0] error_count,
  output logic [INJ_W-1:0] inj_delta,
  output logic             mismatch
);
  // Phase counter must also hold DRAIN_CYCLES when CNT_W is narrow.
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam int PW = (CNT_W > DW) ? CNT_W : DW;
  logic [2:0]       state;
  logic [PW-1:0]    phase_cnt;
  logic [CNT_W-1:0] run_len;
  logic [INJ_W-1:0] snap;
  logic             go, halt, last, counting;
  assign busy        = state == S_WARMUP || state == S_RUN || state == S_DRAIN;
  assign done        = state == S_DONE;
  assign inject_stop = state != S_RUN;
  assign counting    = state == S_RUN || state == S_DRAIN;
  assign go          = (state == S_IDLE || state == S_DONE) && start && !abort;
  assign halt        = busy && abort;
  // A loaded zero behaves like one, giving the minimum single-cycle phase.
  assign last        = phase_cnt <= PW'(1);
  assign mismatch    = done && inj_delta != INJ_W'(error_count);
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= S_IDLE;
      phase_cnt <= '0;
      run_len   <= '0;
      snap      <= '0;
      inj_delta <= '0;
      aborted   <= 1'b0;
    end else begin
      aborted <= halt;
      if (go) begin
        state     <= S_WARMUP;
        phase_cnt <= PW'(cfg_warmup);
        run_len   <= cfg_run;
        inj_delta <= '0;
      end else if (halt) state <= S_IDLE;
      else if (busy) begin
        if (!last) phase_cnt <= phase_cnt - 1'b1;
        else if (state == S_WARMUP) begin
          state     <= S_RUN;
          phase_cnt <= PW'(run_len);
          snap      <= inj_errors;
        end else if (state == S_RUN) begin
          state     <= S_DRAIN;
          phase_cnt <= PW'(DRAIN_CYCLES);
        end else begin
          state     <= S_DONE;
          inj_delta <= inj_errors - snap;
        end
      end
    end
  end
  bert_sat_counter #(.W(CNT_W)) u_bits (
    .clock(clock), .reset(reset), .clear(go),
    .inc(counting && rx_valid), .count(bit_count)
  );
  bert_sat_counter #(.W(CNT_W)) u_errs (
    .clock(clock), .reset(reset), .clear(go),
    .inc(counting && rx_valid && rx_error), .count(error_count)
  );
endmodule

// File: tb/tb_bert_run_controller.sv
// tb_bert_run_controller: randomized runs checked against a phase-schedule model of the run controller.
module tb_bert_run_controller;
  localparam int CW = 32;
  localparam int IW = 64;
  localparam int DRAIN = 16;
  logic          clock = 1'b0, reset = 1'b0, start = 1'b0, abort = 1'b0;
  logic          rx_valid = 1'b0, rx_error = 1'b0;
  logic [CW-1:0] cfg_warmup = '0, cfg_run = '0;
  logic [IW-1:0] inj_errors = '0;
  logic          inject_stop, busy, done, aborted, mismatch;
  logic [CW-1:0] bit_count, error_count;
  logic [IW-1:0] inj_delta;
  logic          s_start = 1'b0;
  logic [3:0]    s_cfg = '0;
  logic          s_stop, s_busy, s_done, s_aborted, s_mismatch;
  logic [3:0]    s_bits, s_errs;
  logic [IW-1:0] s_delta;
  int checks = 0, passes = 0;
  always #5 clock = ~clock;
  bert_run_controller #(.CNT_W(CW), .INJ_W(IW), .DRAIN_CYCLES(DRAIN)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .cfg_warmup(cfg_warmup), .cfg_run(cfg_run), .rx_valid(rx_valid), .rx_error(rx_error),
    .inj_errors(inj_errors), .inject_stop(inject_stop), .busy(busy), .done(done),
    .aborted(aborted), .bit_count(bit_count), .error_count(error_count),
    .inj_delta(inj_delta), .mismatch(mismatch)
  );
  bert_run_controller #(.CNT_W(4), .INJ_W(IW), .DRAIN_CYCLES(DRAIN)) dut_small (
    .clock(clock), .reset(reset), .start(s_start), .abort(1'b0),
    .cfg_warmup(s_cfg), .cfg_run(s_cfg), .rx_valid(rx_valid), .rx_error(rx_error),
    .inj_errors(inj_errors), .inject_stop(s_stop), .busy(s_busy), .done(s_done),
    .aborted(s_aborted), .bit_count(s_bits), .error_count(s_errs),
    .inj_delta(s_delta), .mismatch(s_mismatch)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic check_reset_state(input string tag);
    check({tag, "_stop"}, inject_stop, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_aborted"}, aborted, 0);
    check({tag, "_mismatch"}, mismatch, 0);
    check({tag, "_bits"}, bit_count, 0);
    check({tag, "_errs"}, error_count, 0);
    check({tag, "_delta"}, inj_delta, 0);
  endtask
  // mode 0: every bit valid, no errors, constant total; 1: injector matches detected errors;
  // 2: one injected error never detected; 3: unrelated random injector activity.
  task automatic do_run(input string tag, input int w, input int r, input int mode,
                        input int abort_at, input int rst_at, input int mid_start_at);
    int wm, rm, total, bad, stop_low, ph;
    logic [63:0] snap, fin, eb, ee;
    logic v, e;
    wm = (w == 0) ? 1 : w;
    rm = (r == 0) ? 1 : r;
    total = wm + rm + DRAIN;
    bad = 0; stop_low = 0; eb = 0; ee = 0; snap = 0; fin = 0;
    cfg_warmup = CW'(w); cfg_run = CW'(r); start = 1'b1;
    step();
    start = 1'b0; cfg_warmup = $urandom; cfg_run = $urandom;
    for (int t = 0; t <= total; t++) begin
      ph = (t < wm) ? 1 : (t < wm + rm) ? 2 : (t < total) ? 3 : 4;
      if (inject_stop !== (ph != 2)) bad++;
      if (busy !== (ph >= 1 && ph <= 3)) bad++;
      if (done !== (ph == 4)) bad++;
      if (aborted !== 1'b0) bad++;
      if (!inject_stop) stop_low++;
      if (t == total) break;
      start = (t == mid_start_at);
      v = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      e = (mode == 0) ? 1'b0 : ($urandom_range(0, 99) < 30);
      if (t == abort_at || t == rst_at) v = 1'b0;
      rx_valid = v; rx_error = e;
      if (ph >= 2) begin
        eb += 64'(v);
        ee += 64'(v & e);
        if ((mode == 1 || mode == 2) && v && e) inj_errors += 1;
      end
      if (mode == 2 && t == wm) inj_errors += 1;
      if (mode == 3) inj_errors += IW'($urandom_range(0, 2));
      if (t == wm - 1) snap = inj_errors;
      if (t == total - 1) fin = inj_errors;
      if (t == abort_at) begin
        abort = 1'b1;
        step();
        abort = 1'b0;
        check({tag, "_abort_busy"}, busy, 0);
        check({tag, "_abort_stop"}, inject_stop, 1);
        check({tag, "_abort_done"}, done, 0);
        check({tag, "_abort_pulse"}, aborted, 1);
        check({tag, "_abort_bits"}, bit_count, eb);
        check({tag, "_abort_errs"}, error_count, ee);
        check({tag, "_abort_delta"}, inj_delta, 0);
        step();
        check({tag, "_abort_pulse_end"}, aborted, 0);
        check({tag, "_abort_idle"}, busy, 0);
        return;
      end
      if (t == rst_at) begin
        reset = 1'b0;
        step();
        reset = 1'b1;
        check_reset_state({tag, "_rst"});
        return;
      end
      step();
    end
    start = 1'b0;
    rx_valid = 1'b0;
    check({tag, "_phases"}, bad, 0);
    check({tag, "_stop_low"}, stop_low, rm);
    check({tag, "_bits"}, bit_count, eb);
    check({tag, "_errs"}, error_count, ee);
    check({tag, "_delta"}, inj_delta, fin - snap);
    check({tag, "_mismatch"}, mismatch, 64'((fin - snap) != ee));
    for (int i = 0; i < 3; i++) begin
      rx_valid = 1'b1; rx_error = 1'b1; inj_errors += 5;
      step();
    end
    rx_valid = 1'b0; rx_error = 1'b0;
    check({tag, "_hold"}, {done, bit_count, error_count}, {1'b1, eb[CW-1:0], ee[CW-1:0]});
  endtask
  initial begin
    int sb, sl;
    repeat (3) step();
    check_reset_state("reset");
    check("reset_small", {s_stop, s_busy, s_done, s_bits, s_errs}, {1'b1, 1'b0, 1'b0, 4'd0, 4'd0});
    reset = 1'b1;
    step();
    do_run("basic", 4, 100, 0, -1, -1, -1);
    check("basic_exact_bits", bit_count, 116);
    inj_errors = 64'd10;
    do_run("matched", 3, 25, 1, -1, -1, -1);
    do_run("lost", 2, 15, 2, -1, -1, -1);
    check("lost_flag", mismatch, 1);
    do_run("abort", 5, 100, 3, 55, -1, -1);
    do_run("after_abort", 2, 10, 1, -1, -1, -1);
    do_run("mid_start", 3, 30, 3, -1, -1, 10);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("idle_abort_noop", {done, aborted, busy}, {1'b1, 1'b0, 1'b0});
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    check("start_abort_drop", {done, busy}, {1'b1, 1'b0});
    do_run("min_phases", 0, 0, 1, -1, -1, -1);
    do_run("drain_reset", 2, 10, 3, -1, 17, -1);
    do_run("post_reset", 1, 8, 1, -1, -1, -1);
    for (int i = 0; i < 6; i++)
      do_run($sformatf("rand%0d", i), $urandom_range(0, 6), $urandom_range(0, 40),
             $urandom_range(1, 3), -1, -1, -1);
    sb = 0; sl = 0;
    s_start = 1'b1;
    step();
    s_start = 1'b0; rx_valid = 1'b1; rx_error = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (s_busy) sb++;
      if (!s_stop) sl++;
      step();
    end
    rx_valid = 1'b0; rx_error = 1'b0;
    check("small_busy_cycles", sb, 18);
    check("small_stop_low", sl, 1);
    check("small_bits_sat", s_bits, 15);
    check("small_errs_sat", s_errs, 15);
    check("small_done", s_done, 1);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
